// File: rtl/sram_responder.sv
// Single-port word memory behind an in-order, fixed-latency request/response queue.
// Each accepted request owns one FIFO slot that counts down to its response cycle.
module sram_responder #(
  parameter int AW_WORDS = 10,
  parameter int LATENCY  = 2,
  parameter int QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW    = PW + 1;
  localparam int WORDS = 1 << AW_WORDS;

  localparam logic [CW-1:0] QDEPTH_C     = CW'(QDEPTH);
  localparam logic [CW-1:0] CNT_ONE_C    = CW'(1);
  localparam logic [PW-1:0] PTR_ONE_C    = PW'(1);
  localparam logic [3:0]    TIMER_LOAD_C = 4'(LATENCY - 1);

  logic [31:0]         mem_r [WORDS];
  logic [31:0]         data_r [QDEPTH];
  logic [3:0]          timer_r [QDEPTH];
  logic [QDEPTH-1:0]   valid_r;
  logic [PW-1:0]       wptr_r;
  logic [PW-1:0]       rptr_r;
  logic [CW-1:0]       count_r;
  logic [AW_WORDS-1:0] widx_s;
  logic                push_s;
  logic                pop_s;
  logic                unused_s;

  // Upper address bits alias onto the same word; byte offset is not used.
  assign widx_s   = addr[AW_WORDS+1:2];
  assign unused_s = ^{addr[31:AW_WORDS+2], addr[1:0]};

  assign push_s = req & addr_ok;
  assign pop_s  = data_ok;

  // Flow control and head-of-queue response decode, all forced low during reset.
  always_comb begin
    addr_ok = 1'b0;
    data_ok = 1'b0;
    rdata   = 32'h0;
    if (!reset) begin
      addr_ok = (count_r < QDEPTH_C);
      if (valid_r[rptr_r] && (timer_r[rptr_r] == 4'd0)) begin
        data_ok = 1'b1;
        rdata   = data_r[rptr_r];
      end else begin
        data_ok = 1'b0;
        rdata   = 32'h0;
      end
    end else begin
      addr_ok = 1'b0;
    end
  end

  // Byte-masked memory write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (push_s && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem_r[widx_s][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Response FIFO: push on accept, pop on response, per-slot latency timers.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= '0;
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        timer_r[i] <= 4'd0;
        data_r[i]  <= 32'h0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (valid_r[i] && (timer_r[i] != 4'd0)) begin
          timer_r[i] <= timer_r[i] - 4'd1;
        end
      end
      if (pop_s) begin
        valid_r[rptr_r] <= 1'b0;
        rptr_r          <= rptr_r + PTR_ONE_C;
      end
      // A push only targets a free slot, so it never collides with the popped head.
      if (push_s) begin
        valid_r[wptr_r] <= 1'b1;
        timer_r[wptr_r] <= TIMER_LOAD_C;
        data_r[wptr_r]  <= wr ? 32'h0 : mem_r[widx_s];
        wptr_r          <= wptr_r + PTR_ONE_C;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: three instances (LATENCY 2, 15, 1) each checked
// every cycle against a scoreboard of expected responses and due cycles.
module tb_sram_responder;

  localparam int NI = 3;
  localparam int QD = 4;
  localparam int AW = 10;

  typedef struct {
    logic [31:0] data;
    int          due;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_s   [NI];
  logic        wr_s    [NI];
  logic [3:0]  wstrb_s [NI];
  logic [31:0] addr_s  [NI];
  logic [31:0] wdata_s [NI];
  logic        aok_s   [NI];
  logic        dok_s   [NI];
  logic [31:0] rdata_s [NI];

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 15 : 1);

    sb_t       sb_q[$];
    bit [31:0] mem_m [int];
    logic      aok_m    = 1'b0;
    int        last_due = 0;

    sram_responder #(.AW_WORDS(AW), .LATENCY(L), .QDEPTH(QD)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req_s[g]),
      .wr      (wr_s[g]),
      .wstrb   (wstrb_s[g]),
      .addr    (addr_s[g]),
      .wdata   (wdata_s[g]),
      .addr_ok (aok_s[g]),
      .data_ok (dok_s[g]),
      .rdata   (rdata_s[g])
    );

    // Reference model: accept at this edge (edge number cyc+1), response
    // visible while cyc == accept+L-1, never before the previous response.
    always @(posedge clk) begin : b_model
      int        idx;
      int        due;
      bit [31:0] w;
      if (reset) begin
        sb_q.delete();
        last_due = cyc;
      end else if (req_s[g] && aok_m) begin
        idx = int'(addr_s[g][AW+1:2]);
        due = cyc + L;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        if (wr_s[g]) begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb_s[g][b]) w[8*b +: 8] = wdata_s[g][8*b +: 8];
          end
          mem_m[idx] = w;
          sb_q.push_back('{32'h0, due});
        end else begin
          sb_q.push_back('{w, due});
        end
      end
    end

    always @(negedge clk) begin : b_check
      logic        exp_aok;
      logic        exp_dok;
      logic [31:0] exp_rd;
      exp_aok = !reset && (sb_q.size() < QD);
      exp_dok = 1'b0;
      exp_rd  = 32'h0;
      if (!reset && (sb_q.size() > 0) && (sb_q[0].due == cyc)) begin
        exp_dok = 1'b1;
        exp_rd  = sb_q[0].data;
        void'(sb_q.pop_front());
      end
      aok_m = exp_aok;
      checks++;
      assert (aok_s[g] === exp_aok) else begin
        failures++;
        $error("FAIL addr_ok[%0d] cyc=%0d observed=%b expected=%b", g, cyc, aok_s[g], exp_aok);
      end
      checks++;
      assert (dok_s[g] === exp_dok) else begin
        failures++;
        $error("FAIL data_ok[%0d] cyc=%0d observed=%b expected=%b", g, cyc, dok_s[g], exp_dok);
      end
      checks++;
      assert (rdata_s[g] === exp_rd) else begin
        failures++;
        $error("FAIL rdata[%0d] cyc=%0d observed=%h expected=%h", g, cyc, rdata_s[g], exp_rd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int g, input int n);
    req_s[g] = 1'b0;
    repeat (n) tick();
  endtask

  // Present a request and hold it until the edge at which addr_ok accepts it.
  task automatic send(input int g, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    req_s[g]   = 1'b1;
    wr_s[g]    = w;
    wstrb_s[g] = s;
    addr_s[g]  = a;
    wdata_s[g] = d;
    while (!aok_s[g] && (n < 64)) begin
      tick();
      n++;
    end
    checks++;
    assert (n < 64) else begin
      failures++;
      $error("FAIL send_timeout[%0d] observed=%0d cycles expected<64", g, n);
    end
    tick();
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b1;
    for (int g = 0; g < NI; g++) begin
      req_s[g]   = 1'b0;
      wr_s[g]    = 1'b0;
      wstrb_s[g] = 4'h0;
      addr_s[g]  = 32'h0;
      wdata_s[g] = 32'h0;
    end
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Write then read-after-write on the LATENCY=2 instance.
    send(0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
    send(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
    idle(0, 6);

    // Single-byte merge into an existing word.
    send(0, 1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344);
    send(0, 1'b1, 4'h4, 32'h0000_0020, 32'h00AA_0000);
    send(0, 1'b0, 4'h0, 32'h0000_0020, 32'h0);
    idle(0, 6);

    // wstrb=0 write is a no-op but still responds.
    send(0, 1'b1, 4'hF, 32'h0000_0030, 32'hCAFE_F00D);
    send(0, 1'b1, 4'h0, 32'h0000_0030, 32'hFFFF_FFFF);
    send(0, 1'b0, 4'h0, 32'h0000_0033, 32'h0);
    idle(0, 6);

    // Address aliasing above the word index.
    send(0, 1'b1, 4'hF, 32'h1000_0004, 32'h5A5A_5A5A);
    send(0, 1'b0, 4'h0, 32'h0000_0004, 32'h0);
    idle(0, 6);

    // Randomised traffic over eight pre-initialised words with aliased addresses.
    for (int i = 0; i < 8; i++) send(0, 1'b1, 4'hF, 32'h40 + 32'(4 * i), $urandom);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(0, 1);
      end else begin
        a = $urandom;
        a[11:2] = 10'h010 + 10'($urandom_range(0, 7));
        send(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
      end
    end
    idle(0, 8);

    // LATENCY=15: queue fills after four accepts, six back-to-back reads drain in order.
    for (int i = 0; i < 6; i++) send(1, 1'b1, 4'hF, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 6; i++) send(1, 1'b0, 4'h0, 32'h100 + 32'(4 * i), 32'h0);
    idle(1, 40);

    // One-cycle reset with three requests outstanding discards their responses.
    for (int i = 0; i < 3; i++) send(1, 1'b0, 4'h0, 32'h100 + 32'(4 * i), 32'h0);
    req_s[1] = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(1, 20);

    // LATENCY=1 with req held high: one request and one response per cycle.
    for (int i = 0; i < 4; i++) send(2, 1'b1, 4'hF, 32'h200 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
    for (int i = 0; i < 12; i++) send(2, 1'((i % 3) == 0), 4'hF, 32'h200 + 32'(4 * (i % 4)), 32'h1234_0000 + 32'(i));
    idle(2, 4);

    checks++;
    assert (g_dut[0].sb_q.size() == 0) else begin
      failures++;
      $error("FAIL drain[0] observed=%0d pending expected=0", g_dut[0].sb_q.size());
    end
    checks++;
    assert (g_dut[1].sb_q.size() == 0) else begin
      failures++;
      $error("FAIL drain[1] observed=%0d pending expected=0", g_dut[1].sb_q.size());
    end
    checks++;
    assert (g_dut[2].sb_q.size() == 0) else begin
      failures++;
      $error("FAIL drain[2] observed=%0d pending expected=0", g_dut[2].sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter: AW_WORDS, default 10; memory holds 2^AW_WORDS 32-bit words.
REQ-002 Parameter: LATENCY, default 2; cycles from request acceptance to response, legal range 1..15.
REQ-003 Parameter: QDEPTH, default 4; maximum outstanding requests, power of two, 2..8.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  1  initiator request valid.
REQ-007 wr  input  1  1 = write request, 0 = read request.
REQ-008 wstrb  input  4  byte write enables for writes; bit i enables wdata[8i+7:8i]; ignored for reads.
REQ-009 addr  input  32  byte address; word index = addr[AW_WORDS+1:2].
REQ-010 wdata  input  32  write data.
REQ-011 addr_ok  output  1  request accepted this cycle when req is also high.
REQ-012 data_ok  output  1  response valid this cycle; consumed unconditionally by the initiator.
REQ-013 rdata  output  32  read data, valid while data_ok is high.

Function
REQ-014 A request is accepted on any rising edge where req and addr_ok are both high; otherwise no state changes due to req.
REQ-015 addr_ok is high iff the outstanding count is below QDEPTH and reset is low; addr_ok does not depend on req.
REQ-016 A pop in the same cycle does not free a slot for a push; there is no full-queue bypass.
REQ-017 On acceptance of a write, enabled bytes are written to memory at that edge; disabled bytes are unchanged; wstrb = 0 is a legal no-op write that still produces a response.
REQ-018 On acceptance of a read, the addressed word is captured into the queue entry at that edge, including the effect of any write accepted at an earlier edge.
REQ-019 Each accepted request occupies one FIFO entry holding {rdata, timer}; timer loads LATENCY-1.
REQ-020 Every valid entry's timer decrements by 1 per cycle and saturates at 0.
REQ-021 data_ok is high iff the FIFO is non-empty and the head timer equals 0; the head is popped on that same edge.
REQ-022 Responses are strictly in acceptance order; one response per request, reads and writes alike.
REQ-023 For a request accepted at edge T, data_ok is high no earlier than cycle T+LATENCY, and exactly at T+LATENCY when no older response is pending.
REQ-024 rdata is the captured word for read responses, 32'h0 for write responses, and 32'h0 when data_ok is low.
REQ-025 Outstanding count: +1 on accept, -1 on pop, unchanged when both occur; width is clog2(QDEPTH)+1.
REQ-026 FIFO read and write pointers wrap modulo QDEPTH.
REQ-027 Address bits above AW_WORDS+1 are ignored (aliasing); addr[1:0] is ignored.

Reset
REQ-028 While reset is high, addr_ok = 0, data_ok = 0, rdata = 0, FIFO is empty, pointers are 0, and count is 0.
REQ-029 Reset asserted mid-operation discards all outstanding responses; no data_ok is issued for them after reset deasserts.
REQ-030 Memory contents are not cleared by reset; simulation initial contents are 0.
REQ-031 addr_ok is high in the first cycle after reset deasserts.

Verification
REQ-032 LATENCY=2: write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF at edge T, then read 0x10 at T+1 -> data_ok at T+2 with rdata 0, and data_ok at T+3 with rdata 0xDEADBEEF.
REQ-033 Word 0x20 holds 0x11223344; write wstrb 0x4, wdata 0x00AA0000; then read 0x20 -> rdata 0x11AA3344.
REQ-034 QDEPTH=4, LATENCY=15: 6 back-to-back reads -> addr_ok low after the 4th accept, rises the cycle after the first pop; all 6 responses arrive in order.
REQ-035 Assert reset for 1 cycle with 3 outstanding requests -> no data_ok for 3 cycles after reset; addr_ok = 1 after reset deasserts.
REQ-036 AW_WORDS=10: write 0x5A5A5A5A to addr 0x1000_0004, read addr 0x0000_0004 -> rdata 0x5A5A5A5A (alias).
REQ-037 LATENCY=1, req held high continuously -> addr_ok and data_ok both high every cycle from the second cycle on, sustaining one request per cycle.
